// File: rtl/mcsr_pkg.sv
// Shared types and default sizes for the MCSR SpMV result collector.
// Imported by the collector top, its result bank and the stream interface users.
package mcsr_pkg;

  localparam int NUM_ROWS_DEF  = 5;
  localparam int DATA_W_DEF    = 32;
  localparam int ROW_IDX_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } collect_state_t;

endpackage

// File: rtl/mcsr_row_collector_if.sv
// Row-ordered result stream (valid/ready) leaving the collector.
// master = collector side, slave = consumer (host DMA / writeback).
interface mcsr_row_collector_if #(
  parameter int DATA_W    = 32,
  parameter int ROW_IDX_W = 3
);

  logic                 valid;
  logic                 ready;
  logic [DATA_W-1:0]    data;
  logic [ROW_IDX_W-1:0] row;
  logic                 last;

  modport master (
    output valid,
    output data,
    output row,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  row,
    input  last,
    output ready
  );

endinterface

// File: rtl/mcsr_result_bank.sv
// Row-indexed result registers with per-row captured bits.
// clr loads the captured mask from init_mask and zeroes every word.
module mcsr_result_bank
  import mcsr_pkg::*;
#(
  parameter int NUM_ROWS  = NUM_ROWS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ROW_IDX_W = ROW_IDX_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [NUM_ROWS-1:0]        init_mask,
  input  logic [NUM_ROWS-1:0]        we,
  input  logic [NUM_ROWS*DATA_W-1:0] wdata,
  input  logic [ROW_IDX_W-1:0]       rd_idx,
  output logic [DATA_W-1:0]          rd_data,
  output logic [NUM_ROWS-1:0]        captured
);

  logic [DATA_W-1:0] mem [NUM_ROWS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        mem[i] <= '0;
      end
      captured <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        mem[i] <= '0;
      end
      captured <= init_mask;
    end else begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        if (we[i]) begin
          mem[i]      <= wdata[i*DATA_W +: DATA_W];
          captured[i] <= 1'b1;
        end
      end
    end
  end

  // Look-ahead index may point one past the last row; read 0 there.
  always_comb begin
    rd_data = '0;
    if (32'(rd_idx) < NUM_ROWS) begin
      rd_data = mem[rd_idx];
    end
  end

endmodule

// File: rtl/mcsr_row_collector.sv
// Collects per-row MAC results in any order, then streams y in row order.
// Optional watchdog: define MCSR_COLLECT_TIMEOUT_EN.
module mcsr_row_collector
  import mcsr_pkg::*;
#(
  parameter int NUM_ROWS       = NUM_ROWS_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ROW_IDX_W      = ROW_IDX_W_DEF,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       ap_rst_n,
  input  logic                       start,
  input  logic [NUM_ROWS-1:0]        row_en,
  input  logic [NUM_ROWS*DATA_W-1:0] y_data,
  input  logic [NUM_ROWS-1:0]        y_vld,
  mcsr_row_collector_if.master       out,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun,
  output logic                       timeout
);

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(NUM_ROWS - 1);

  if ((2**ROW_IDX_W) < NUM_ROWS || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mcsr_row_collector: bad parameters");
  end

  collect_state_t state_q, state_d;

  logic [NUM_ROWS-1:0]  row_en_q, row_en_d;
  logic [ROW_IDX_W-1:0] rd_ptr_q, rd_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [ROW_IDX_W-1:0] out_row_q, out_row_d;
  logic                 out_last_q, out_last_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;

  logic                 bank_clr;
  logic [NUM_ROWS-1:0]  bank_we;
  logic [NUM_ROWS-1:0]  captured;
  logic [NUM_ROWS-1:0]  next_captured;
  logic                 all_in;
  logic [ROW_IDX_W-1:0] rd_idx;
  logic [DATA_W-1:0]    rd_data;
  logic                 hs;
  logic                 expire;

  assign bank_clr = (state_q == IDLE) && start;
  assign bank_we  = (state_q == COLLECT) ? (y_vld & row_en_q) : '0;
  assign next_captured = captured | bank_we;
  assign all_in = &next_captured;
  assign hs     = out_valid_q && out.ready;
  // Index of the word to present after the next handshake.
  assign rd_idx = (state_q == DRAIN) ? ROW_IDX_W'(rd_ptr_q + 1'b1) : '0;

  mcsr_result_bank #(
    .NUM_ROWS  (NUM_ROWS),
    .DATA_W    (DATA_W),
    .ROW_IDX_W (ROW_IDX_W)
  ) u_bank (
    .clk       (clk),
    .rst_n     (ap_rst_n),
    .clr       (bank_clr),
    .init_mask (~row_en),
    .we        (bank_we),
    .wdata     (y_data),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .captured  (captured)
  );

`ifdef MCSR_COLLECT_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;

  assign expire  = (wd_q + 32'd1) == 32'(TIMEOUT_CYCLES);
  assign timeout = timeout_q;

  always_ff @(posedge clk) begin
    if (!ap_rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    row_en_d    = row_en_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
`ifdef MCSR_COLLECT_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          row_en_d  = row_en;
          overrun_d = 1'b0;
          state_d   = COLLECT;
`ifdef MCSR_COLLECT_TIMEOUT_EN
          wd_d      = '0;
          timeout_d = 1'b0;
`endif
        end
      end
      COLLECT: begin
        if (|(bank_we & captured)) begin
          overrun_d = 1'b1;
        end
`ifdef MCSR_COLLECT_TIMEOUT_EN
        wd_d = wd_q + 32'd1;
        if (!all_in && expire) begin
          timeout_d = 1'b1;
        end
`endif
        if (all_in || expire) begin
          state_d     = DRAIN;
          rd_ptr_d    = '0;
          out_valid_d = 1'b1;
          out_row_d   = '0;
          out_last_d  = (LAST_ROW == '0);
          // Row 0 may be landing on this very edge; forward it.
          out_data_d  = bank_we[0] ? y_data[DATA_W-1:0] : rd_data;
        end
      end
      DRAIN: begin
        if (|y_vld) begin
          overrun_d = 1'b1;
        end
        if (hs) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end else begin
            rd_ptr_d   = rd_idx;
            out_row_d  = rd_idx;
            out_data_d = rd_data;
            out_last_d = (rd_idx == LAST_ROW);
          end
        end
      end
      DONE: begin
        if (|y_vld) begin
          overrun_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      row_en_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_en_q    <= row_en_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out.valid = out_valid_q;
  assign out.data  = out_data_q;
  assign out.row   = out_row_q;
  assign out.last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mcsr_row_collector.sv
// Directed bench for mcsr_row_collector; watchdog case runs only when
// MCSR_COLLECT_TIMEOUT_EN is defined (TIMEOUT_CYCLES=16 here).
module tb_mcsr_row_collector;

  localparam int NR = 5;
  localparam int DW = 32;
  localparam int RW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              ap_rst_n;
  logic              start;
  logic [NR-1:0]     row_en;
  logic [NR*DW-1:0]  y_data;
  logic [NR-1:0]     y_vld;
  logic              busy;
  logic              done;
  logic              overrun;
  logic              timeout;

  mcsr_row_collector_if #(.DATA_W(DW), .ROW_IDX_W(RW)) out_if ();

  mcsr_row_collector #(
    .NUM_ROWS       (NR),
    .DATA_W         (DW),
    .ROW_IDX_W      (RW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk      (clk),
    .ap_rst_n (ap_rst_n),
    .start    (start),
    .row_en   (row_en),
    .y_data   (y_data),
    .y_vld    (y_vld),
    .out      (out_if),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun),
    .timeout  (timeout)
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] ev [NR];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe1(input int r, input logic [DW-1:0] d);
    y_vld = '0;
    y_vld[r] = 1'b1;
    y_data[r*DW +: DW] = d;
    tick();
    y_vld = '0;
  endtask

  task automatic begin_pass(input logic [NR-1:0] en, input string tag);
    row_en = en;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic drain(input logic [DW-1:0] e [NR], input string tag);
    out_if.ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), 64'(out_if.valid), 64'd1);
      chk($sformatf("%s_row%0d", tag, i), 64'(out_if.row), 64'(i));
      chk($sformatf("%s_data%0d", tag, i), 64'(out_if.data), 64'(e[i]));
      chk($sformatf("%s_last%0d", tag, i), 64'(out_if.last),
          64'(i == NR - 1));
      tick();
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_valid_end"}, 64'(out_if.valid), 64'd0);
  endtask

  initial begin
    ap_rst_n = 1'b0;
    start = 1'b0;
    row_en = '0;
    y_vld = '0;
    y_data = '0;
    out_if.ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(out_if.valid), 64'd0);
    chk("rst_data", 64'(out_if.data), 64'd0);
    chk("rst_row", 64'(out_if.row), 64'd0);
    chk("rst_last", 64'(out_if.last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    ap_rst_n = 1'b1;
    tick();

    // out-of-order strobes
    begin_pass(5'b11111, "t1");
    strobe1(3, 32'h30);
    chk("t1_wait", 64'(out_if.valid), 64'd0);
    strobe1(0, 32'h00);
    strobe1(4, 32'h40);
    strobe1(1, 32'h10);
    strobe1(2, 32'h20);
    ev = '{32'h00, 32'h10, 32'h20, 32'h30, 32'h40};
    drain(ev, "t1");
    chk("t1_overrun", 64'(overrun), 64'd0);

    // start in DONE ignored, accepted next IDLE cycle
    row_en = 5'b11111;
    start = 1'b1;
    tick();
    chk("done_start_busy", 64'(busy), 64'd0);
    chk("done_pulse_end", 64'(done), 64'd0);
    tick();
    start = 1'b0;
    chk("idle_start_busy", 64'(busy), 64'd1);

    // all rows in one cycle
    y_vld = 5'b11111;
    y_data = {32'h104, 32'h103, 32'h102, 32'h101, 32'h100};
    tick();
    y_vld = '0;
    ev = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104};
    drain(ev, "t2");
    tick();

    // partial row_en with stray strobe on a disabled row
    begin_pass(5'b10101, "t3");
    strobe1(0, 32'hA0);
    strobe1(1, 32'hDEAD);
    chk("t3_stray_ovr", 64'(overrun), 64'd0);
    chk("t3_wait", 64'(out_if.valid), 64'd0);
    strobe1(2, 32'hA2);
    strobe1(4, 32'hA4);
    ev = '{32'hA0, 32'h0, 32'hA2, 32'h0, 32'hA4};
    drain(ev, "t3");
    chk("t3_overrun", 64'(overrun), 64'd0);
    tick();

    // duplicate strobe on row 2
    begin_pass(5'b11111, "t4");
    strobe1(2, 32'hAA);
    chk("t4_ovr_first", 64'(overrun), 64'd0);
    strobe1(2, 32'hBB);
    chk("t4_ovr_dup", 64'(overrun), 64'd1);
    strobe1(0, 32'h1);
    strobe1(1, 32'h2);
    strobe1(3, 32'h4);
    strobe1(4, 32'h5);
    ev = '{32'h1, 32'h2, 32'hBB, 32'h4, 32'h5};
    drain(ev, "t4");
    chk("t4_overrun_sticky", 64'(overrun), 64'd1);
    tick();

    // empty row_en: one COLLECT cycle, then zeros
    begin_pass(5'b00000, "t5");
    chk("t5_ovr_cleared", 64'(overrun), 64'd0);
    chk("t5_wait", 64'(out_if.valid), 64'd0);
    tick();
    ev = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    drain(ev, "t5");
    tick();

    // backpressure, then reset mid-drain
    begin_pass(5'b11111, "t6");
    y_vld = 5'b11111;
    y_data = {32'h504, 32'h503, 32'h502, 32'h501, 32'h500};
    tick();
    y_vld = '0;
    out_if.ready = 1'b1;
    chk("t6_v0", 64'(out_if.valid), 64'd1);
    chk("t6_d0", 64'(out_if.data), 64'h500);
    tick();
    out_if.ready = 1'b0;
    chk("t6_r1", 64'(out_if.row), 64'd1);
    chk("t6_d1", 64'(out_if.data), 64'h501);
    tick();
    chk("t6_stall1_r", 64'(out_if.row), 64'd1);
    chk("t6_stall1_d", 64'(out_if.data), 64'h501);
    chk("t6_stall1_v", 64'(out_if.valid), 64'd1);
    tick();
    chk("t6_stall2_r", 64'(out_if.row), 64'd1);
    chk("t6_stall2_d", 64'(out_if.data), 64'h501);
    out_if.ready = 1'b1;
    tick();
    chk("t6_r2", 64'(out_if.row), 64'd2);
    chk("t6_d2", 64'(out_if.data), 64'h502);
    ap_rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", 64'(out_if.valid), 64'd0);
    chk("t6_rst_data", 64'(out_if.data), 64'd0);
    chk("t6_rst_row", 64'(out_if.row), 64'd0);
    chk("t6_rst_last", 64'(out_if.last), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_ovr", 64'(overrun), 64'd0);
    ap_rst_n = 1'b1;
    out_if.ready = 1'b0;
    tick();

`ifdef MCSR_COLLECT_TIMEOUT_EN
    // watchdog: row 4 never reports
    begin_pass(5'b11111, "t7");
    for (int i = 0; i < 4; i++) begin
      strobe1(i, 32'h60 + 32'(i));
    end
    repeat (11) tick();
    chk("t7_before_v", 64'(out_if.valid), 64'd0);
    chk("t7_before_busy", 64'(busy), 64'd1);
    chk("t7_before_to", 64'(timeout), 64'd0);
    tick();
    chk("t7_to", 64'(timeout), 64'd1);
    ev = '{32'h60, 32'h61, 32'h62, 32'h63, 32'h0};
    drain(ev, "t7");
    chk("t7_to_sticky", 64'(timeout), 64'd1);
    tick();
`else
    chk("timeout_tied", 64'(timeout), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
